gemm_result_reader: RTL and testbench

GEMM_RESULT_READER -- requirements
Module: gemm_result_reader

---
 rtl/gemm_result_reader.sv | 191 +++++++++++++++++++
 tb/tb_gemm_result_reader.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_result_reader.sv
// gemm_result_reader: streams the M x N result matrix out of the C SRAM.
// Reads are issued one address per cycle. A 2-entry output FIFO holds returned
// data, and a read is only issued while (FIFO occupancy + reads in flight) < 2,
// so returned data always has a slot. When the FIFO is empty, returning SRAM
// data goes straight to the output, giving the first beat 2 cycles after start.
//
// Build option: define GEMM_RESULT_READER_COLMAJOR_EN to traverse column-major
// (m inner loop, C^T order). The default build traverses row-major (n inner).
//
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   start_i                   one-cycle readout request (honoured in IDLE only)
//   M_size_i, N_size_i        matrix dimensions, latched on an accepted start
//   sram_c_addr_o, sram_c_re_o     SRAM C read address / enable
//   sram_c_rdata_i            SRAM C read data, valid 1 cycle after sram_c_re_o
//   data_o, valid_o, ready_i, last_o   output stream (last_o on final beat)
//   busy_o                    high in READ and DRAIN
//   done_o                    one-cycle completion pulse, registered off DONE
module gemm_result_reader #(
    parameter int unsigned OutDataWidth  = 128,
    parameter int unsigned AddrWidth     = 16,
    parameter int unsigned SizeAddrWidth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    output logic                     sram_c_re_o,
    input  logic [OutDataWidth-1:0]  sram_c_rdata_i,
    output logic [OutDataWidth-1:0]  data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     last_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0] state;
    logic [1:0] next_state;

    logic [SizeAddrWidth-1:0] m_size;
    logic [SizeAddrWidth-1:0] n_size;
    logic [SizeAddrWidth-1:0] m_cnt;
    logic [SizeAddrWidth-1:0] n_cnt;
    logic                     m_end;
    logic                     n_end;
    logic                     last_addr;
    logic                     issue;

    // rvalid/rlast track the read issued in the previous cycle (data on the bus now)
    logic                     rvalid;
    logic                     rlast;

    logic [OutDataWidth-1:0]  fifo_data [2];
    logic [1:0]               fifo_last;
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic [1:0]               count;
    logic                     fifo_nonempty;
    logic                     pop;
    logic                     pop_fifo;
    logic                     push;

    assign m_end     = (m_cnt == m_size - SizeAddrWidth'(1));
    assign n_end     = (n_cnt == n_size - SizeAddrWidth'(1));
    assign last_addr = m_end && n_end;

    // Credit check: buffered entries plus the read now returning must leave a slot
    assign issue = (state == READ) && ((count + 2'(rvalid)) < 2'd2);

    assign sram_c_re_o   = issue;
    assign sram_c_addr_o = AddrWidth'(m_cnt) * AddrWidth'(n_size) + AddrWidth'(n_cnt);

    // Output stream: FIFO head when occupied, otherwise fall through from SRAM
    assign fifo_nonempty = (count != 2'd0);
    assign valid_o       = fifo_nonempty || rvalid;
    assign data_o        = fifo_nonempty ? fifo_data[rd_ptr] :
                           (rvalid ? sram_c_rdata_i : '0);
    assign last_o        = fifo_nonempty ? fifo_last[rd_ptr] : (rvalid && rlast);

    assign pop      = valid_o && ready_i;
    assign pop_fifo = pop && fifo_nonempty;
    // Returning data is buffered unless it is consumed directly on the bypass
    assign push     = rvalid && !(!fifo_nonempty && ready_i);

    assign busy_o = (state == READ) || (state == DRAIN);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    if ((M_size_i == '0) || (N_size_i == '0)) begin
                        next_state = DONE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ: begin
                if (issue && last_addr) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && last_o) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Size latch and traversal counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_size <= '0;
            n_size <= '0;
            m_cnt  <= '0;
            n_cnt  <= '0;
        end else if ((state == IDLE) && start_i) begin
            m_size <= M_size_i;
            n_size <= N_size_i;
            m_cnt  <= '0;
            n_cnt  <= '0;
        end else if (issue) begin
`ifdef GEMM_RESULT_READER_COLMAJOR_EN
            if (m_end) begin
                m_cnt <= '0;
                n_cnt <= n_end ? '0 : n_cnt + SizeAddrWidth'(1);
            end else begin
                m_cnt <= m_cnt + SizeAddrWidth'(1);
            end
`else
            if (n_end) begin
                n_cnt <= '0;
                m_cnt <= m_end ? '0 : m_cnt + SizeAddrWidth'(1);
            end else begin
                n_cnt <= n_cnt + SizeAddrWidth'(1);
            end
`endif
        end
    end

    // In-flight tracking, output FIFO and done pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid       <= 1'b0;
            rlast        <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= '0;
            done_o       <= 1'b0;
        end else begin
            rvalid <= issue;
            rlast  <= issue && last_addr;
            if (push) begin
                fifo_data[wr_ptr] <= sram_c_rdata_i;
                fifo_last[wr_ptr] <= rlast;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop_fifo) begin
                rd_ptr <= ~rd_ptr;
            end
            count  <= count + 2'(push) - 2'(pop_fifo);
            done_o <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_gemm_result_reader.sv
module tb_gemm_result_reader;

    localparam int unsigned DW = 128;
    localparam int unsigned AW = 16;
    localparam int unsigned SW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [SW-1:0] m_size;
    logic [SW-1:0] n_size;
    logic [AW-1:0] sram_c_addr_o;
    logic          sram_c_re_o;
    logic [DW-1:0] sram_rdata;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic          last_o;
    logic          busy_o;
    logic          done_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    logic [AW-1:0] exp_addr [$];
    logic [DW-1:0] exp_data [$];
    logic          exp_last [$];

    int re_cnt, beat_cnt, done_cnt;
    int first_re_cyc, last_re_cyc, first_valid_cyc, done_cyc;
    int issued, popped;
    bit stalled_prev;
    logic [DW-1:0] prev_data;
    logic prev_last;
    int start_cyc;

    gemm_result_reader dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start_i),
        .M_size_i       (m_size),
        .N_size_i       (n_size),
        .sram_c_addr_o  (sram_c_addr_o),
        .sram_c_re_o    (sram_c_re_o),
        .sram_c_rdata_i (sram_rdata),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .last_o         (last_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a, 16'hC0DE, ~a, 16'h5A5A, a ^ 16'h1234, 16'hBEEF, a + 16'd7, 16'h0F0F};
    endfunction

    // SRAM C model: one-cycle read latency, garbage on idle cycles
    always @(posedge clk) begin
        if (sram_c_re_o === 1'b1) sram_rdata <= mem_word(sram_c_addr_o);
        else sram_rdata <= {$urandom, $urandom, $urandom, $urandom};
    end

    // Stream monitor and scoreboard
    always @(negedge clk) begin
        if (!mon_en) begin
            exp_addr.delete();
            exp_data.delete();
            exp_last.delete();
            re_cnt = 0; beat_cnt = 0; done_cnt = 0;
            first_re_cyc = -1; last_re_cyc = -1; first_valid_cyc = -1; done_cyc = -1;
            issued = 0; popped = 0; stalled_prev = 1'b0;
        end else begin
            automatic int outst = issued - popped;
            automatic logic [AW-1:0] ea;
            automatic logic [DW-1:0] ed;
            automatic logic el;
            checks++;
            if (outst > 2 || (sram_c_re_o === 1'b1 && outst >= 2)) begin
                failures++;
                $display("FAIL credit: outstanding=%0d re=%0b required <=2 and <2 on read", outst, sram_c_re_o);
            end
            if (sram_c_re_o === 1'b1) begin
                if (first_re_cyc < 0) first_re_cyc = cyc;
                last_re_cyc = cyc;
                re_cnt++;
                checks++;
                if (exp_addr.size() == 0) begin
                    failures++;
                    $display("FAIL read_addr: unexpected read of %0d", sram_c_addr_o);
                end else begin
                    ea = exp_addr.pop_front();
                    if (sram_c_addr_o !== ea) begin
                        failures++;
                        $display("FAIL read_addr: got %0d want %0d", sram_c_addr_o, ea);
                    end
                end
            end
            if (stalled_prev) begin
                checks++;
                if (valid_o !== 1'b1 || data_o !== prev_data || last_o !== prev_last) begin
                    failures++;
                    $display("FAIL stall_hold: valid=%0b data=%h last=%0b want valid=1 data=%h last=%0b",
                             valid_o, data_o, last_o, prev_data, prev_last);
                end
            end
            if (valid_o === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (valid_o === 1'b1 && ready_i === 1'b1) begin
                beat_cnt++;
                checks++;
                if (exp_data.size() == 0) begin
                    failures++;
                    $display("FAIL beat: unexpected beat data=%h", data_o);
                end else begin
                    ed = exp_data.pop_front();
                    el = exp_last.pop_front();
                    if (data_o !== ed || last_o !== el) begin
                        failures++;
                        $display("FAIL beat %0d: data=%h last=%0b want data=%h last=%0b",
                                 beat_cnt - 1, data_o, last_o, ed, el);
                    end
                end
            end else if (valid_o !== 1'b1) begin
                checks++;
                if (last_o !== 1'b0) begin
                    failures++;
                    $display("FAIL last_no_valid: last=%0b want 0", last_o);
                end
            end
            if (done_o === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            stalled_prev = (valid_o === 1'b1) && (ready_i !== 1'b1);
            prev_data = data_o;
            prev_last = last_o;
            issued += int'(sram_c_re_o === 1'b1);
            popped += int'(valid_o === 1'b1 && ready_i === 1'b1);
        end
    end

    task automatic begin_scenario();
        mon_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    // Push the expected address/data/last sequence, then pulse start
    task automatic do_start(input int m, input int n);
        int k;
        logic [AW-1:0] a;
        k = 0;
`ifdef GEMM_RESULT_READER_COLMAJOR_EN
        for (int j = 0; j < n; j++) begin
            for (int i = 0; i < m; i++) begin
`else
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < n; j++) begin
`endif
                a = AW'(i * n + j);
                exp_addr.push_back(a);
                exp_data.push_back(mem_word(a));
                exp_last.push_back(k == m * n - 1);
                k++;
            end
        end
        m_size = SW'(m);
        n_size = SW'(n);
        start_i = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_i = 1'b0;
        ready_i = 1'b1;
        m_size = '0;
        n_size = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (sram_c_addr_o !== '0) begin failures++; $display("FAIL reset_addr: got %0d want 0", sram_c_addr_o); end
        checks++; if (sram_c_re_o !== 1'b0) begin failures++; $display("FAIL reset_re: got %0b want 0", sram_c_re_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", valid_o); end
        checks++; if (last_o !== 1'b0) begin failures++; $display("FAIL reset_last: got %0b want 0", last_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b want 0", done_o); end
        checks++; if (data_o !== '0) begin failures++; $display("FAIL reset_data: got %h want 0", data_o); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        bit ok;
        begin_scenario();
        ready_i = 1'b1;
        do_start(2, 3);
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL basic_busy: got %0b want 1", busy_o); end
        wait_done(40, ok);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (!ok) begin failures++; $display("FAIL basic_timeout: done not seen want done"); end
        checks++; if (beat_cnt != 6 || re_cnt != 6) begin failures++; $display("FAIL basic_count: beats=%0d reads=%0d want 6/6", beat_cnt, re_cnt); end
        checks++; if (first_re_cyc != start_cyc + 1 || last_re_cyc != start_cyc + 6) begin
            failures++; $display("FAIL basic_read_cycles: first=%0d last=%0d want %0d/%0d", first_re_cyc, last_re_cyc, start_cyc + 1, start_cyc + 6); end
        checks++; if (first_valid_cyc != start_cyc + 2) begin failures++; $display("FAIL basic_latency: first valid at %0d want %0d", first_valid_cyc, start_cyc + 2); end
        checks++; if (done_cnt != 1 || done_cyc != start_cyc + 9) begin failures++; $display("FAIL basic_done: count=%0d cyc=%0d want 1 at %0d", done_cnt, done_cyc, start_cyc + 9); end
        checks++; if (exp_data.size() != 0 || busy_o !== 1'b0) begin failures++; $display("FAIL basic_end: pending=%0d busy=%0b want 0/0", exp_data.size(), busy_o); end
    endtask

    task automatic test_stall();
        bit ok;
        begin_scenario();
        ready_i = 1'b1;
        do_start(4, 4);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            ready_i = ~ready_i;
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        ready_i = 1'b1;
        checks++; if (!ok) begin failures++; $display("FAIL stall_timeout: done not seen want done"); end
        checks++; if (beat_cnt != 16 || re_cnt != 16) begin failures++; $display("FAIL stall_count: beats=%0d reads=%0d want 16/16", beat_cnt, re_cnt); end
        checks++; if (exp_data.size() != 0 || exp_addr.size() != 0) begin failures++; $display("FAIL stall_pending: data=%0d addr=%0d want 0/0", exp_data.size(), exp_addr.size()); end
    endtask

    task automatic test_zero();
        bit ok;
        begin_scenario();
        ready_i = 1'b1;
        do_start(0, 5);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL zero_busy: got %0b want 0", busy_o); end
        wait_done(10, ok);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (!ok) begin failures++; $display("FAIL zero_timeout: done not seen want done"); end
        checks++; if (re_cnt != 0 || beat_cnt != 0) begin failures++; $display("FAIL zero_activity: reads=%0d beats=%0d want 0/0", re_cnt, beat_cnt); end
        checks++; if (done_cnt != 1 || done_cyc != start_cyc + 2) begin failures++; $display("FAIL zero_done: count=%0d cyc=%0d want 1 at %0d", done_cnt, done_cyc, start_cyc + 2); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        begin_scenario();
        ready_i = 1'b1;
        do_start(3, 3);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (beat_cnt >= 4) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++; if (!ok) begin failures++; $display("FAIL midrst_timeout: beats=%0d want 4", beat_cnt); end
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (sram_c_re_o !== 1'b0 || sram_c_addr_o !== '0) begin failures++; $display("FAIL midrst_sram: re=%0b addr=%0d want 0/0", sram_c_re_o, sram_c_addr_o); end
        checks++; if (valid_o !== 1'b0 || last_o !== 1'b0 || data_o !== '0) begin failures++; $display("FAIL midrst_stream: valid=%0b last=%0b data=%h want 0", valid_o, last_o, data_o); end
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin failures++; $display("FAIL midrst_status: busy=%0b done=%0b want 0/0", busy_o, done_o); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        begin_scenario();
        do_start(1, 1);
        wait_done(20, ok);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (!ok) begin failures++; $display("FAIL midrst_restart_timeout: done not seen want done"); end
        checks++; if (beat_cnt != 1 || re_cnt != 1 || done_cnt != 1) begin
            failures++; $display("FAIL midrst_restart: beats=%0d reads=%0d dones=%0d want 1/1/1", beat_cnt, re_cnt, done_cnt); end
        checks++; if (exp_data.size() != 0) begin failures++; $display("FAIL midrst_pending: %0d want 0", exp_data.size()); end
    endtask

    task automatic test_busy_restart();
        bit ok;
        begin_scenario();
        ready_i = 1'b1;
        do_start(2, 2);
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL restart_busy: got %0b want 1", busy_o); end
        m_size = SW'(5);
        n_size = SW'(5);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_done(40, ok);
        repeat (6) @(posedge clk);
        #1;
        checks++; if (!ok) begin failures++; $display("FAIL restart_timeout: done not seen want done"); end
        checks++; if (beat_cnt != 4 || re_cnt != 4 || done_cnt != 1) begin
            failures++; $display("FAIL restart_count: beats=%0d reads=%0d dones=%0d want 4/4/1", beat_cnt, re_cnt, done_cnt); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_reset_mid();
        test_busy_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
